// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and arbiter FSM
// states shared by the ALU-sharing slice.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick,
// first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any_gnt
);

  // Scan N slots starting at ptr; first hit wins.
  always_comb begin
    int s;
    logic [W-1:0] idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_gnt    = 1'b0;
    s          = 0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr) + i;
      if (s >= N) s = s - N;
      idx = W'(s);
      if (!any_gnt && req[idx]) begin
        any_gnt         = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one
// external ALU; capture -> execute -> hold result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [3:0]              alu_ctrl,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    alu_zero,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] vld_q, vld_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               zero_q, zero_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [PW-1:0]      gnt_idx;
  logic               any_gnt;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req        (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_oh),
    .gnt_idx    (gnt_idx),
    .any_gnt    (any_gnt)
  );

  // Grants are offered only while idle and out of reset.
  assign req_ready  = (rst_n && state_q == IDLE) ? gnt_oh : '0;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = vld_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

  // Transaction FSM; operand regs keep last issue.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    vld_d   = vld_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          a_d     = req_a[gnt_idx*XLEN +: XLEN];
          b_d     = req_b[gnt_idx*XLEN +: XLEN];
          ctrl_d  = req_op[gnt_idx*4 +: 4];
          owner_d = gnt_idx;
          ptr_d   = (gnt_idx == LAST) ? '0
                    : gnt_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d          = alu_result;
        zero_d         = alu_zero;
        vld_d          = '0;
        vld_d[owner_q] = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          vld_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      vld_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b0000;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

endmodule
